// File: rtl/bus_pkg.sv
// Shared types and the address decode helper for the round-robin bus interconnect.
package bus_pkg;

   // Widest supported host/device index and address; per-instance widths are narrower.
   localparam int MaxHostIdxW = 3;
   localparam int MaxDevIdxW  = 4;
   localparam int MaxAddrW    = 64;

   typedef logic [MaxHostIdxW-1:0] host_idx_t;
   typedef logic [MaxDevIdxW-1:0]  dev_idx_t;

   // Response phase bookkeeping, captured in the grant cycle.
   typedef struct packed {
      logic      valid;
      host_idx_t host;
      dev_idx_t  dev;
      logic      err;
   } resp_t;

   // A device claims an address when the masked bits equal its masked base.
   function automatic logic addr_match(input logic [MaxAddrW-1:0] addr,
                                       input logic [MaxAddrW-1:0] base,
                                       input logic [MaxAddrW-1:0] mask);
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/bus_rr_xbar_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
module rr_arbiter #(
   parameter int  N    = 2,
   localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N-1:0]    req_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   logic [IdxW-1:0] rr_q;
   logic [N-1:0]    gnt;
   logic [IdxW-1:0] idx;
   logic            valid;

   // Search hosts from rr_q upward, then wrap around to the hosts below rr_q.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid && req_i[i] && (IdxW'(i) >= rr_q)) begin
            valid  = 1'b1;
            gnt[i] = 1'b1;
            idx    = IdxW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!valid && req_i[i] && (IdxW'(i) < rr_q)) begin
            valid  = 1'b1;
            gnt[i] = 1'b1;
            idx    = IdxW'(i);
         end
      end
   end

   // Grants are suppressed while reset is held, even though they are combinational.
   assign gnt_o   = rst_ni ? gnt : '0;
   assign valid_o = rst_ni & valid;
   assign idx_o   = idx;

   if (N == 1) begin : g_single
      // A single host needs no rotation.
      assign rr_q = '0;
   end else begin : g_multi
      // Move the pointer just past the winner so it loses priority next cycle.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rr_q <= '0;
         end else if (valid) begin
            rr_q <= (idx == IdxW'(N - 1)) ? '0 : idx + IdxW'(1);
         end
      end
   end

endmodule

// File: rtl/bus_rr_xbar.sv
// N-host to M-device shared bus: round-robin grant, address decode, registered response.
module bus_rr_xbar
   import bus_pkg::*;
#(
   parameter int NrHosts   = 2,
   parameter int NrDevices = 3,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NrHosts-1:0]             host_req_i,
   output logic [NrHosts-1:0]             host_gnt_o,
   input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]             host_we_i,
   input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
   input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
   output logic [NrHosts-1:0]             host_rvalid_o,
   output logic [NrHosts-1:0]             host_err_o,
   output logic [NrHosts*DataWidth-1:0]   host_rdata_o,
   output logic [NrDevices-1:0]           device_req_o,
   output logic [NrDevices*AddrWidth-1:0] device_addr_o,
   output logic [NrDevices-1:0]           device_we_o,
   output logic [NrDevices*DataWidth/8-1:0] device_be_o,
   output logic [NrDevices*DataWidth-1:0] device_wdata_o,
   input  logic [NrDevices*DataWidth-1:0] device_rdata_i,
   input  logic [NrDevices*AddrWidth-1:0] cfg_device_addr_base_i,
   input  logic [NrDevices*AddrWidth-1:0] cfg_device_addr_mask_i
);

   localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
   localparam int BeW      = DataWidth / 8;

   logic [HostIdxW-1:0]  arb_idx;
   logic                 arb_valid;
   logic [AddrWidth-1:0] g_addr;
   logic                 g_we;
   logic [BeW-1:0]       g_be;
   logic [DataWidth-1:0] g_wdata;
   logic                 hit;
   logic [DevIdxW-1:0]   dev;
   resp_t                resp_q;
   logic                 resp_we_q;
   logic [DataWidth-1:0] rdata_word;

   rr_arbiter #(.N(NrHosts)) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (host_req_i),
      .gnt_o   (host_gnt_o),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Select the granted host's request fields.
   always_comb begin
      g_addr  = '0;
      g_we    = 1'b0;
      g_be    = '0;
      g_wdata = '0;
      for (int h = 0; h < NrHosts; h++) begin
         if (arb_idx == HostIdxW'(h)) begin
            g_addr  = host_addr_i[h*AddrWidth +: AddrWidth];
            g_we    = host_we_i[h];
            g_be    = host_be_i[h*BeW +: BeW];
            g_wdata = host_wdata_i[h*DataWidth +: DataWidth];
         end
      end
   end

   // Decode the granted address; on overlapping windows the lowest index wins.
   always_comb begin
      hit = 1'b0;
      dev = '0;
      for (int d = 0; d < NrDevices; d++) begin
         if (!hit && addr_match(MaxAddrW'(g_addr),
                                MaxAddrW'(cfg_device_addr_base_i[d*AddrWidth +: AddrWidth]),
                                MaxAddrW'(cfg_device_addr_mask_i[d*AddrWidth +: AddrWidth]))) begin
            hit = 1'b1;
            dev = DevIdxW'(d);
         end
      end
   end

   // Select exactly the decoded device; nothing when idle, in reset or unmapped.
   always_comb begin
      device_req_o = '0;
      for (int d = 0; d < NrDevices; d++) begin
         if (arb_valid && hit && (dev == DevIdxW'(d))) device_req_o[d] = 1'b1;
      end
   end

   assign device_addr_o  = {NrDevices{g_addr}};
   assign device_we_o    = {NrDevices{g_we}};
   assign device_be_o    = {NrDevices{g_be}};
   assign device_wdata_o = {NrDevices{g_wdata}};

   // Remember who was granted and where it went, so the response can be routed next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_q    <= '0;
         resp_we_q <= 1'b0;
      end else begin
         resp_q.valid <= arb_valid;
         if (arb_valid) begin
            resp_q.host <= host_idx_t'(arb_idx);
            resp_q.dev  <= dev_idx_t'(dev);
            resp_q.err  <= !hit;
            resp_we_q   <= g_we;
         end
      end
   end

   // Route the response strobe to the owning host; read data only for mapped reads.
   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      rdata_word    = '0;
      for (int h = 0; h < NrHosts; h++) begin
         if (resp_q.valid && (resp_q.host == host_idx_t'(h))) begin
            host_rvalid_o[h] = 1'b1;
            host_err_o[h]    = resp_q.err;
         end
      end
      if (resp_q.valid && !resp_q.err && !resp_we_q) begin
         for (int d = 0; d < NrDevices; d++) begin
            if (resp_q.dev == dev_idx_t'(d)) rdata_word = device_rdata_i[d*DataWidth +: DataWidth];
         end
      end
   end

   assign host_rdata_o = {NrHosts{rdata_word}};

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Testbench for bus_rr_xbar with two hosts and three devices (CLINT, RAM, console).
module tb_bus_rr_xbar;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [1:0]  h_req;
   logic [31:0] h_addr [2];
   logic [1:0]  h_we;
   logic [3:0]  h_be [2];
   logic [31:0] h_wdata [2];
   logic [31:0] cfg_base [3];
   logic [31:0] cfg_mask [3];
   logic [31:0] dev_rdata [3];

   logic [1:0]  host_gnt_o, host_rvalid_o, host_err_o;
   logic [63:0] host_rdata_o;
   logic [2:0]  device_req_o, device_we_o;
   logic [95:0] device_addr_o, device_wdata_o;
   logic [11:0] device_be_o;

   int checks = 0;
   int errors = 0;
   int rr = 0;

   always #5 clk = ~clk;

   bus_rr_xbar dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_ni),
      .host_req_i             (h_req),
      .host_gnt_o             (host_gnt_o),
      .host_addr_i            ({h_addr[1], h_addr[0]}),
      .host_we_i              (h_we),
      .host_be_i              ({h_be[1], h_be[0]}),
      .host_wdata_i           ({h_wdata[1], h_wdata[0]}),
      .host_rvalid_o          (host_rvalid_o),
      .host_err_o             (host_err_o),
      .host_rdata_o           (host_rdata_o),
      .device_req_o           (device_req_o),
      .device_addr_o          (device_addr_o),
      .device_we_o            (device_we_o),
      .device_be_o            (device_be_o),
      .device_wdata_o         (device_wdata_o),
      .device_rdata_i         ({dev_rdata[2], dev_rdata[1], dev_rdata[0]}),
      .cfg_device_addr_base_i ({cfg_base[2], cfg_base[1], cfg_base[0]}),
      .cfg_device_addr_mask_i ({cfg_mask[2], cfg_mask[1], cfg_mask[0]})
   );

   // Content each device returns for an address (RAM word 0x10 holds 0xDEADBEEF).
   function automatic logic [31:0] dev_data(input int d, input logic [31:0] a);
      if (d == 1 && a == 32'h10) return 32'hDEAD_BEEF;
      return a ^ 32'h5A5A_0000 ^ (32'(d) << 28);
   endfunction

   // Devices answer one cycle after being selected.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++)
         if (device_req_o[d]) dev_rdata[d] <= dev_data(d, device_addr_o[d*32 +: 32]);
   end

   // Reference model: first requester at or after the pointer, lowest matching device.
   function automatic int model_grant(input logic [1:0] req, input int ptr);
      for (int k = 0; k < 2; k++) if (req[(ptr + k) % 2]) return (ptr + k) % 2;
      return -1;
   endfunction

   function automatic int model_decode(input logic [31:0] a);
      for (int d = 0; d < 3; d++) if ((a & cfg_mask[d]) == (cfg_base[d] & cfg_mask[d])) return d;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge with inputs applied; checks request and response phases.
   task automatic check_cycle(output logic [1:0] gnt_seen, output logic [2:0] dreq_seen);
      int g, d;
      logic [1:0] eg;
      logic [2:0] ed;
      logic p_v, p_err;
      int p_host;
      logic [31:0] p_data;
      #2;
      g  = model_grant(h_req, rr);
      eg = '0;
      ed = '0;
      d  = -1;
      if (g >= 0) begin
         eg[g] = 1'b1;
         d = model_decode(h_addr[g]);
         if (d >= 0) ed[d] = 1'b1;
      end
      gnt_seen  = host_gnt_o;
      dreq_seen = device_req_o;
      chk("gnt", host_gnt_o, eg);
      chk("device_req", device_req_o, ed);
      if (g >= 0) begin
         chk("dev_addr", device_addr_o, {3{h_addr[g]}});
         chk("dev_we", device_we_o, {3{h_we[g]}});
         chk("dev_be", device_be_o, {3{h_be[g]}});
         chk("dev_wdata", device_wdata_o, {3{h_wdata[g]}});
         rr = (g + 1) % 2;
      end
      p_v    = (g >= 0);
      p_host = (g >= 0) ? g : 0;
      p_err  = (d < 0);
      p_data = (g >= 0 && d >= 0 && !h_we[g]) ? dev_data(d, h_addr[g]) : 32'h0;
      @(posedge clk);
      #1;
      chk("rvalid", host_rvalid_o, p_v ? (2'b01 << p_host) : 2'b00);
      chk("err", host_err_o, (p_v && p_err) ? (2'b01 << p_host) : 2'b00);
      if (p_v) chk("rdata", host_rdata_o, {2{p_data}});
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [31:0] a0, a1;
      logic [3:0]  be0;
      logic [31:0] wd0, wd1;
      logic [1:0]  exp_gnt;
      logic [2:0]  exp_dreq;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [1:0] gs, last_g;
      logic [2:0] ds;
      logic [31:0] bases [6];

      vecs[0]  = '{2'b01, 2'b00, 32'h0000_0010, 32'h0, 4'hF, 32'h0, 32'h0, 2'b01, 3'b010};
      vecs[1]  = '{2'b10, 2'b10, 32'h0, 32'h0400_0000, 4'hF, 32'h0, 32'h1111_2222, 2'b10, 3'b000};
      vecs[2]  = '{2'b11, 2'b00, 32'h0000_0100, 32'h0020_0010, 4'hF, 32'h0, 32'h0, 2'b01, 3'b010};
      vecs[3]  = '{2'b11, 2'b00, 32'h0000_0100, 32'h0020_0010, 4'hF, 32'h0, 32'h0, 2'b10, 3'b100};
      vecs[4]  = '{2'b11, 2'b00, 32'h0000_0100, 32'h0020_0010, 4'hF, 32'h0, 32'h0, 2'b01, 3'b010};
      vecs[5]  = '{2'b11, 2'b00, 32'h0000_0100, 32'h0020_0010, 4'hF, 32'h0, 32'h0, 2'b10, 3'b100};
      vecs[6]  = '{2'b01, 2'b01, 32'h0020_0000, 32'h0, 4'b0010, 32'h0000_AB00, 32'h0, 2'b01, 3'b100};
      vecs[7]  = '{2'b00, 2'b00, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 2'b00, 3'b000};
      vecs[8]  = '{2'b01, 2'b00, 32'h0200_0008, 32'h0, 4'hF, 32'h0, 32'h0, 2'b01, 3'b001};
      vecs[9]  = '{2'b01, 2'b00, 32'h0200_000C, 32'h0, 4'hF, 32'h0, 32'h0, 2'b01, 3'b001};
      vecs[10] = '{2'b10, 2'b00, 32'h0, 32'h0020_0004, 4'hF, 32'h0, 32'h0, 2'b10, 3'b100};

      // Device map: CLINT, 1 MiB RAM at 0, console page.
      cfg_base[0] = 32'h0200_0000; cfg_mask[0] = 32'hFFFF_0000;
      cfg_base[1] = 32'h0000_0000; cfg_mask[1] = 32'hFFF0_0000;
      cfg_base[2] = 32'h0020_0000; cfg_mask[2] = 32'hFFFF_F000;

      // Reset with requests pending: grants and selects must stay low.
      rst_ni = 1'b0;
      h_req = 2'b11; h_we = 2'b00;
      h_addr[0] = 32'h10; h_addr[1] = 32'h0020_0000;
      h_be[0] = 4'hF; h_be[1] = 4'hF; h_wdata[0] = '0; h_wdata[1] = '0;
      #12;
      chk("reset_gnt", host_gnt_o, 2'b00);
      chk("reset_dreq", device_req_o, 3'b000);
      chk("reset_rvalid", host_rvalid_o, 2'b00);
      chk("reset_err", host_err_o, 2'b00);
      chk("reset_rdata", host_rdata_o, 64'h0);
      @(negedge clk);
      h_req = 2'b00;
      rst_ni = 1'b1;
      rr = 0;

      // Directed table: single read, unmapped write, contention, byte-enable write, idle, back-to-back.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         h_req = vecs[i].req; h_we = vecs[i].we;
         h_addr[0] = vecs[i].a0; h_addr[1] = vecs[i].a1;
         h_be[0] = vecs[i].be0; h_be[1] = 4'hF;
         h_wdata[0] = vecs[i].wd0; h_wdata[1] = vecs[i].wd1;
         check_cycle(gs, ds);
         chk($sformatf("tbl%0d_gnt", i), gs, vecs[i].exp_gnt);
         chk($sformatf("tbl%0d_dreq", i), ds, vecs[i].exp_dreq);
      end

      // Overlapping windows: device 0 must win over the wider device 2 window.
      @(negedge clk);
      cfg_base[2] = 32'h0200_0000; cfg_mask[2] = 32'hFFF0_0000;
      h_req = 2'b01; h_we = 2'b00; h_addr[0] = 32'h0200_0004;
      check_cycle(gs, ds);
      chk("overlap_dreq", ds, 3'b001);
      @(negedge clk);
      cfg_base[2] = 32'h0020_0000; cfg_mask[2] = 32'hFFFF_F000;
      h_req = 2'b00;
      check_cycle(gs, ds);

      // Reset while a response is on the bus: it disappears and never comes back.
      @(negedge clk);
      h_req = 2'b10; h_we = 2'b00; h_addr[1] = 32'h0000_0040;
      check_cycle(gs, ds);
      #1;
      rst_ni = 1'b0;
      h_req = 2'b11; h_addr[0] = 32'h0000_0080;
      #1;
      chk("midrst_rvalid", host_rvalid_o, 2'b00);
      chk("midrst_rdata", host_rdata_o, 64'h0);
      chk("midrst_gnt", host_gnt_o, 2'b00);
      @(negedge clk);
      rst_ni = 1'b1;
      rr = 0;
      #1;
      chk("postrst_rvalid", host_rvalid_o, 2'b00);
      check_cycle(gs, ds);
      chk("postrst_first_gnt", gs, 2'b01);

      // Random traffic; an ungranted request is held with its fields unchanged.
      bases[0] = 32'h0000_0000; bases[1] = 32'h000F_0000; bases[2] = 32'h0020_0000;
      bases[3] = 32'h0200_0000; bases[4] = 32'h0400_0000; bases[5] = 32'h8000_0000;
      last_g = gs;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         for (int h = 0; h < 2; h++) begin
            if (!(h_req[h] && !last_g[h])) begin
               h_req[h]   = ($urandom_range(0, 3) != 0);
               h_we[h]    = 1'($urandom_range(0, 1));
               h_addr[h]  = bases[$urandom_range(0, 5)] + (32'($urandom_range(0, 255)) << 2);
               h_be[h]    = 4'($urandom_range(0, 15));
               h_wdata[h] = $urandom;
            end
         end
         check_cycle(gs, ds);
         last_g = gs;
      end

      @(negedge clk);
      h_req = 2'b00;
      check_cycle(gs, ds);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
